// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// VGA timing generator (640x480 at the default parameters).  Divides the
// system clock down to a one-clk pixel strobe, runs the horizontal and
// vertical position counters, and drives the active-low monitor sync lines.
// Its position and visible-area outputs feed the RGB multiplexer.  frame_tick
// is the once-per-frame motion update strobe.
//
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN
//   defined   : frame_cnt is an 8-bit register that counts frame_tick pulses
//               and wraps from 255 to 0.
//   undefined : frame_cnt is tied to zero and no register is built.
//
// Ports
//   clk        in   1  system clock (single clock domain)
//   reset      in   1  asynchronous, active-high reset
//   hsync      out  1  horizontal sync, active-low, registered
//   vsync      out  1  vertical sync, active-low, registered
//   video_on   out  1  high while (pix_x, pix_y) is inside the visible area
//   p_tick     out  1  one-clk pixel strobe, registered
//   pix_x      out 10  current pixel column (horizontal counter)
//   pix_y      out 10  current line (vertical counter)
//   frame_tick out  1  one-clk pulse per frame, at pixel (0, V_DISPLAY+1)
//   frame_cnt  out  8  frame counter (zero unless VGA_SYNC_FRAME_CNT_EN)
//
// Parameter legality: TICK_DIV in 1..4.  The horizontal and vertical totals
// must each be at most 1024 so that the 10-bit counters cover them.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int TICK_DIV  = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Divider terminal count: the divider wraps after this value.
  localparam logic [1:0] TDIV_LAST = 2'(TICK_DIV - 1);

  // Counter terminal values.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Visible area limits (exclusive upper bounds).
  localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS = 10'(V_DISPLAY);

  // Sync pulse windows (inclusive bounds).
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Line on which the per-frame motion tick fires (first line after the
  // visible area plus one, so object updates land well inside blanking).
  localparam logic [9:0] FT_LINE = 10'(V_DISPLAY + 1);

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  logic [1:0] tdiv_r;
  logic [1:0] tdiv_next_s;
  logic       p_tick_r;
  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;
  logic [9:0] h_next_s;
  logic [9:0] v_next_s;
  logic       hsync_r;
  logic       vsync_r;
  logic       frame_tick_s;

  // Next divider phase: count 0..TICK_DIV-1 and wrap.
  always_comb begin
    tdiv_next_s = tdiv_r;
    if (tdiv_r == TDIV_LAST) begin
      tdiv_next_s = 2'd0;
    end else begin
      tdiv_next_s = tdiv_r + 2'd1;
    end
  end

  // Divider phase and pixel strobe registers.  The strobe is registered from
  // the terminal phase, so after reset release it first appears on the
  // TICK_DIV-th edge and is held high continuously when TICK_DIV is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdiv_r   <= 2'd0;
      p_tick_r <= 1'b0;
    end else begin
      tdiv_r   <= tdiv_next_s;
      p_tick_r <= (tdiv_r == TDIV_LAST);
    end
  end

  // Next position: the horizontal counter moves on every pixel strobe and the
  // vertical counter moves only when the line wraps.  On the last pixel of
  // the last line both counters return to zero together.
  always_comb begin
    h_next_s = h_cnt_r;
    v_next_s = v_cnt_r;
    if (p_tick_r) begin
      if (h_cnt_r == H_LAST) begin
        h_next_s = 10'd0;
        if (v_cnt_r == V_LAST) begin
          v_next_s = 10'd0;
        end else begin
          v_next_s = v_cnt_r + 10'd1;
        end
      end else begin
        h_next_s = h_cnt_r + 10'd1;
      end
    end else begin
      h_next_s = h_cnt_r;
      v_next_s = v_cnt_r;
    end
  end

  // Position counters plus the sync registers.  The syncs are computed from
  // the next-state counters so that they change on the same edge as the
  // position they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else begin
      h_cnt_r <= h_next_s;
      v_cnt_r <= v_next_s;
      hsync_r <= ~in_window(h_next_s, HS_FIRST, HS_LAST);
      vsync_r <= ~in_window(v_next_s, VS_FIRST, VS_LAST);
    end
  end

  // Frame strobe: only one pixel of the frame matches, and only on its
  // strobe clk, so the pulse is exactly one clk wide per frame.
  always_comb begin
    frame_tick_s = 1'b0;
    if (p_tick_r && (h_cnt_r == 10'd0) && (v_cnt_r == FT_LINE)) begin
      frame_tick_s = 1'b1;
    end else begin
      frame_tick_s = 1'b0;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Frame counter: advances on the frame strobe clk and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_tick_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`else
  assign frame_cnt = 8'd0;
`endif

  assign p_tick     = p_tick_r;
  assign pix_x      = h_cnt_r;
  assign pix_y      = v_cnt_r;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign frame_tick = frame_tick_s;
  assign video_on   = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Scoreboard bench for vga_sync_gen on a shrunken raster (12 x 10 pixels,
// TICK_DIV=2) so that hundreds of frames fit in a short run.  The stimulus
// process pushes the expected output for every pixel strobe into a queue,
// computed from the strobe index alone; the monitor pops one entry per
// strobe and compares.  Between strobes the outputs must equal the entry at
// the head of the queue.  A second process measures line and frame
// periods.  Directed checks cover reset, the first strobe and an
// asynchronous reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int TD = 2;
  localparam int HD = 8;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VD = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HD + HF + HS + HB;       // 12
  localparam int VT = VD + VF + VS + VB;       // 10
  localparam int FRAME_TICKS = HT * VT;        // 120
  localparam int FRAME_CLKS  = FRAME_TICKS * TD;
  localparam int VIS_TICKS   = HD * VD;        // 48
  localparam int RUN_FRAMES  = 257;

  // {x, y, hsync, vsync, video_on, frame_tick, frame_cnt}
  localparam logic [31:0] RESET_PACK = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_tick;
  logic [7:0] frame_cnt;

  vga_sync_gen #(
    .TICK_DIV (TD),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hsync     (hsync),
    .vsync     (vsync),
    .video_on  (video_on),
    .p_tick    (p_tick),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .frame_tick(frame_tick),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int  n_vec  = 0;
  int  n_bad  = 0;
  int  m_n;
  int  m_frames;
  int  ft_seen = 0;
  bit  mon_en  = 1'b0;

  function automatic string fmt(input logic [31:0] v);
    return $sformatf("x=%0d y=%0d hs=%0b vs=%0b von=%0b ft=%0b fc=%0d",
                     v[31:22], v[21:12], v[11], v[10], v[9], v[8], v[7:0]);
  endfunction

  function automatic logic [31:0] dut_pack();
    return {pix_x, pix_y, hsync, vsync, video_on, frame_tick, frame_cnt};
  endfunction

  task automatic chk_s(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk_v(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference raster model: strobe index -> expected outputs.
  task automatic push_ticks(input int k);
    int x;
    int y;
    logic [31:0] e;
    for (int i = 0; i < k; i++) begin
      x = m_n % HT;
      y = (m_n / HT) % VT;
      e[31:22] = 10'(x);
      e[21:12] = 10'(y);
      e[11]    = !((x >= HD + HF) && (x < HD + HF + HS));
      e[10]    = !((y >= VD + VF) && (y < VD + VF + VS));
      e[9]     = (x < HD) && (y < VD);
      e[8]     = (x == 0) && (y == VD + 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
      e[7:0]   = 8'(m_frames);
`else
      e[7:0]   = 8'd0;
`endif
      exp_q.push_back(e);
      if (e[8]) m_frames++;
      m_n++;
    end
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && mon_en) begin
        if (p_tick) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_tick: got {%s} expected no strobe", fmt(dut_pack()));
          end else begin
            e = exp_q.pop_front();
            chk_s("tick", dut_pack(), e);
            if (frame_tick) ft_seen++;
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q[0];
          e[8] = 1'b0;
          chk_s("hold", dut_pack(), e);
        end
      end
    end
  end

  // Period measurements: strobes per line, clks per frame, visible strobes.
  initial begin
    int cyc = 0;
    int last_vfall = 0;
    int h_ticks = 0;
    int von_ticks = 0;
    bit hs_prev = 1'b1;
    bit vs_prev = 1'b1;
    bit h_valid = 1'b0;
    bit v_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        h_valid = 1'b0; v_valid = 1'b0;
        hs_prev = 1'b1; vs_prev = 1'b1;
        h_ticks = 0;    von_ticks = 0;
      end else begin
        cyc++;
        if (p_tick) begin
          h_ticks++;
          if (video_on) von_ticks++;
        end
        if (hs_prev && !hsync) begin
          if (h_valid) chk_v("line_ticks", h_ticks, HT);
          h_ticks = 0;
          h_valid = 1'b1;
        end
        if (vs_prev && !vsync) begin
          if (v_valid) begin
            chk_v("frame_clks", cyc - last_vfall, FRAME_CLKS);
            chk_v("visible_ticks", von_ticks, VIS_TICKS);
          end
          last_vfall = cyc;
          von_ticks = 0;
          v_valid = 1'b1;
        end
        hs_prev = hsync;
        vs_prev = vsync;
      end
    end
  end

  // Stimulus.
  initial begin
    int budget;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_s("reset_state", dut_pack(), RESET_PACK);
      chk_v("reset_ptick", int'(p_tick), 0);
    end

    m_n = 0;
    m_frames = 0;
    push_ticks(RUN_FRAMES * FRAME_TICKS + 2);
    mon_en = 1'b1;
    reset = 1'b0;

    @(negedge clk);
    chk_v("edge1_ptick", int'(p_tick), 0);
    chk_v("edge1_x", int'(pix_x), 0);
    @(negedge clk);
    chk_v("edge2_ptick", int'(p_tick), 1);
    chk_v("edge2_x", int'(pix_x), 0);
    @(negedge clk);
    chk_v("edge3_ptick", int'(p_tick), 0);
    chk_v("edge3_x", int'(pix_x), 1);

    wait_drain((RUN_FRAMES * FRAME_TICKS + 2) * TD + 100);
    mon_en = 1'b0;
    chk_v("frame_ticks_seen", ft_seen, RUN_FRAMES);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk_v("frame_cnt_257", int'(frame_cnt), 1);
`else
    chk_v("frame_cnt_off", int'(frame_cnt), 0);
`endif

    // Asynchronous reset between edges while inside both sync pulses.
    budget = 2 * FRAME_CLKS;
    while (!(pix_x == 10'd9 && pix_y == 10'd7) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk_v("reach_9_7", budget > 0 ? 1 : 0, 1);
    chk_v("pre_reset_hsync", int'(hsync), 0);
    chk_v("pre_reset_vsync", int'(vsync), 0);
    #2 reset = 1'b1;
    #1 chk_s("async_reset", dut_pack(), RESET_PACK);
    chk_v("async_reset_ptick", int'(p_tick), 0);
    @(negedge clk);
    @(negedge clk);

    // One more full frame from reset, covering the last-pixel wrap.
    m_n = 0;
    m_frames = 0;
    push_ticks(FRAME_TICKS + 2);
    mon_en = 1'b1;
    reset = 1'b0;
    wait_drain((FRAME_TICKS + 2) * TD + 100);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480 timing generator for the war game display path. Divides the system clock down to a pixel tick, runs the horizontal and vertical pixel counters, and drives the monitor sync lines. Downstream, its `video_on`, `pix_x` and `pix_y` outputs feed the graphics/RGB multiplexer, and its `frame_tick` serves as the once-per-frame positioning tick for object motion.

## Interface
Parameters:
- `TICK_DIV`, 2: system clocks per pixel. Legal range 1..4; 50 MHz / 2 gives 25 MHz.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `hsync` out 1: horizontal sync, active-low, registered.
- `vsync` out 1: vertical sync, active-low, registered.
- `video_on` out 1: high while the current pixel is in the visible area.
- `p_tick` out 1: one-clk pixel strobe.
- `pix_x` out 10: current pixel column.
- `pix_y` out 10: current line.
- `frame_tick` out 1: one-clk pulse, once per frame.
- `frame_cnt` out 8: frame counter (see Configuration).

## Operation
- **Tick divider.** Counter `tdiv` counts 0..TICK_DIV-1 and then wraps.
  - `p_tick` = (`tdiv` == TICK_DIV-1).
  - With TICK_DIV=1, `p_tick` is constantly 1 outside reset.
- **Horizontal counter.** `h_cnt` advances only when `p_tick` is high.
  - Range 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (default 800).
  - At H_TOTAL-1 with `p_tick`, it wraps to 0.
- **Vertical counter.** `v_cnt` advances only when `p_tick` is high and `h_cnt` == H_TOTAL-1.
  - Range 0..V_TOTAL-1 (default 525); wraps to 0.
  - On the last pixel of the last line, both counters wrap to 0 on the same edge.
- **Pixel position.** `pix_x` = `h_cnt`, `pix_y` = `v_cnt`, driven directly from the registers.
- **Sync outputs.**
  - `hsync` is 0 iff `h_cnt` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (default 656..751).
  - `vsync` is 0 iff `v_cnt` is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (default 490..491).
  - Both are registered from next-state counter values, so they stay cycle-coherent with `pix_x`/`pix_y`.
- **Visible area.** `video_on` = (`h_cnt` < H_DISPLAY) && (`v_cnt` < V_DISPLAY), combinational from the counter registers.
- **Frame tick.** `frame_tick` = `p_tick` && `h_cnt`==0 && `v_cnt`==V_DISPLAY+1 (default line 481). It is high for exactly one clk per frame.
- **Width rule.** H_TOTAL and V_TOTAL must be ≤ 1024. Counters are 10 bits and never take out-of-range values.

## Timing
- **Reset values.** `tdiv`=0, `pix_x`=0, `pix_y`=0, `hsync`=1, `vsync`=1, `p_tick`=0, `frame_tick`=0, `frame_cnt`=0, `video_on`=1 (position 0,0 is visible).
- **Reset assertion.** Reset takes effect immediately, without a clk edge, and holds for its whole duration.
- **Reset release.** For TICK_DIV=N, the first `p_tick` occurs on the N-th rising clk edge after release (N=1: the first edge). `pix_x` becomes 1 on the edge following that tick.
- **Reset mid-line or mid-frame.** Position returns to 0,0 and the divider phase restarts. Partial lines are not completed.
- **Defaults.** 800 ticks per line, 525 lines per frame, 420,000 ticks = 840,000 clks per frame at TICK_DIV=2.
- **Latency.** Zero cycles between counter values and the `hsync`/`vsync`/`video_on`/`frame_tick` they imply.
- **Stability.** All outputs are stable across the TICK_DIV-1 non-tick clks.

## Configuration
- **Macro `VGA_SYNC_FRAME_CNT_EN`.**
- **Defined:** `frame_cnt` is an 8-bit register.
  - Increments on the same clk as `frame_tick` and wraps 255→0.
  - Clears asynchronously on `reset`.
- **Undefined:** `frame_cnt` is tied to 8'd0 and no register is built. All other behaviour is identical.

## Test plan
- **Reset and first tick.** Hold `reset` for 5 clks with TICK_DIV=2, then release. Required: all outputs equal their reset values during reset; first `p_tick` on the 2nd clk edge after release; `pix_x`=1 one clk later.
- **Line timing.** Measure one line. Required: 800 `p_tick`s between `hsync` falling edges; `hsync` low for exactly 96 ticks starting at `pix_x`=656; `video_on` drops at `pix_x`=640.
- **Frame timing.** Run two frames. Required: `vsync` low only on lines 490–491; 525 lines per frame; 840,000 clks between `vsync` falling edges; `video_on` high for exactly 307,200 ticks per frame.
- **Frame tick and counter.** Run 257 frames with `VGA_SYNC_FRAME_CNT_EN` defined. Required: exactly one `frame_tick` per frame, at `pix_x`=0, `pix_y`=481; `frame_cnt` reads 0 again after 256 frames and 1 after 257. With the macro undefined, `frame_cnt` stays 0.
- **Async reset mid-frame.** Assert `reset` between clk edges at position (300,200). Required: `pix_x`/`pix_y` read 0/0 before the next clk edge; `hsync`/`vsync` read 1.
- **Wrap edge.** Observe the last pixel (799,524). Required: on the next `p_tick` edge both counters wrap to (0,0) together; `video_on` rises; no `frame_tick` is generated.
